// File: rtl/serial_adder_if.sv
// serial_adder_if
//  Groups the start/busy/done handshake, operand bus and result bus of the
//  serial adder into one bundle.
//  Signals:
//    start_in            request, seen by the adder only while busy_out==0
//    a_in, b_in, c_in    operands and carry-in, captured on an accepted start
//    sum_out, carry_out  registered result, updated only at completion
//    busy_out            high while an operation is in progress
//    done_out            one-cycle pulse when sum_out/carry_out just updated
//    ovf_out             signed overflow, present only with SERIAL_ADDER_OVF_EN
//  Modports: master (requester side), slave (adder side).
//  Optional feature macro: SERIAL_ADDER_OVF_EN
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             busy_out;
    logic             done_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_out;
`endif

    modport master (
        output start_in,
        output a_in,
        output b_in,
        output c_in,
        input  sum_out,
        input  carry_out,
        input  busy_out,
        input  done_out
`ifdef SERIAL_ADDER_OVF_EN
        ,
        input  ovf_out
`endif
    );

    modport slave (
        input  start_in,
        input  a_in,
        input  b_in,
        input  c_in,
        output sum_out,
        output carry_out,
        output busy_out,
        output done_out
`ifdef SERIAL_ADDER_OVF_EN
        ,
        output ovf_out
`endif
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//  Multi-cycle ripple adder: a_in + b_in + c_in computed DIGIT bits per clock
//  over N = WIDTH/DIGIT clocks with one DIGIT-wide adder slice and a carry flop.
//  Ports:
//    clk_in   clock, all state on the rising edge
//    rst_in   synchronous reset, active-high, wins over everything
//    bus      serial_adder_if.slave (start/operands in, sum/carry/busy/done out)
//  Parameters: WIDTH (>=1), DIGIT (WIDTH % DIGIT must be 0).
//  Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    serial_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One DIGIT-wide full-adder slice; bit DIGIT of the result is the carry.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             ci
    );
        digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] psum_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
`ifdef SERIAL_ADDER_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             ovf_r;
`endif

    logic [DIGIT:0]         digit_s;
    logic [WIDTH+DIGIT-1:0] psum_wide_s;
    logic [WIDTH-1:0]       psum_next_s;
    logic [WIDTH-1:0]       a_next_s;
    logic [WIDTH-1:0]       b_next_s;

    // Slice result for the current digit and the shifted operand/partial-sum values.
    // The new digit enters the partial sum from the MSB end; after N digits the
    // first digit has reached bit 0. The wide concat avoids an empty slice when N==1.
    always_comb begin
        digit_s     = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
        psum_wide_s = {digit_s[DIGIT-1:0], psum_r};
        psum_next_s = psum_wide_s[WIDTH+DIGIT-1:DIGIT];
        a_next_s    = a_r >> DIGIT;
        b_next_s    = b_r >> DIGIT;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start_in) begin
                        a_r     <= bus.a_in;
                        b_r     <= bus.b_in;
                        carry_r <= bus.c_in;
                        psum_r  <= {WIDTH{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
`ifdef SERIAL_ADDER_OVF_EN
                        a_msb_r <= bus.a_in[WIDTH-1];
                        b_msb_r <= bus.b_in[WIDTH-1];
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_r     <= a_next_s;
                    b_r     <= b_next_s;
                    psum_r  <= psum_next_s;
                    carry_r <= digit_s[DIGIT];
                    if (cnt_r == LAST) begin
                        sum_r   <= psum_next_s;
                        cout_r  <= digit_s[DIGIT];
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= IDLE;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_r   <= (a_msb_r == b_msb_r) && (psum_next_s[WIDTH-1] != a_msb_r);
`endif
                    end else begin
                        cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.sum_out   = sum_r;
    assign bus.carry_out = cout_r;
    assign bus.busy_out  = busy_r;
    assign bus.done_out  = done_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf_out   = ovf_r;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//  Randomized self-checking bench for serial_adder. Three instances share clock
//  and reset: WIDTH=8 with DIGIT=1, 4 and 8 (N = 8, 2, 1). Expected results come
//  from plain integer addition of the operands.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if_d1 ();
    serial_adder_if #(.WIDTH(8)) if_d4 ();
    serial_adder_if #(.WIDTH(8)) if_d8 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (.clk_in(clk), .rst_in(rst), .bus(if_d1));
    serial_adder #(.WIDTH(8), .DIGIT(4)) dut_d4 (.clk_in(clk), .rst_in(rst), .bus(if_d4));
    serial_adder #(.WIDTH(8), .DIGIT(8)) dut_d8 (.clk_in(clk), .rst_in(rst), .bus(if_d8));

    int total = 0;
    int bad   = 0;

    logic [7:0] prev_sum   [3];
    logic       prev_carry [3];
    logic       prev_ovf   [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
        case (w)
            0: begin if_d1.start_in = s; if_d1.a_in = a; if_d1.b_in = b; if_d1.c_in = c; end
            1: begin if_d4.start_in = s; if_d4.a_in = a; if_d4.b_in = b; if_d4.c_in = c; end
            default: begin if_d8.start_in = s; if_d8.a_in = a; if_d8.b_in = b; if_d8.c_in = c; end
        endcase
    endtask

    // {ovf, done, busy, carry, sum[7:0]}
    function automatic logic [11:0] outs(input int w);
        logic ov;
        ov = 1'b0;
        case (w)
            0: begin
`ifdef SERIAL_ADDER_OVF_EN
                ov = if_d1.ovf_out;
`endif
                outs = {ov, if_d1.done_out, if_d1.busy_out, if_d1.carry_out, if_d1.sum_out};
            end
            1: begin
`ifdef SERIAL_ADDER_OVF_EN
                ov = if_d4.ovf_out;
`endif
                outs = {ov, if_d4.done_out, if_d4.busy_out, if_d4.carry_out, if_d4.sum_out};
            end
            default: begin
`ifdef SERIAL_ADDER_OVF_EN
                ov = if_d8.ovf_out;
`endif
                outs = {ov, if_d8.done_out, if_d8.busy_out, if_d8.carry_out, if_d8.sum_out};
            end
        endcase
    endfunction

    function automatic int lat(input int w);
        case (w)
            0:       lat = 8;
            1:       lat = 2;
            default: lat = 1;
        endcase
    endfunction

    // One operation: start, wait (bounded) for done, check latency, hold and result.
    task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input bit keep_start, input string tag);
        logic [8:0]  full;
        logic        exp_ovf;
        logic [11:0] o;
        int          cyc;
        bit          seen;
        full    = {1'b0, a} + {1'b0, b} + {8'd0, c};
        exp_ovf = (a[7] == b[7]) && (full[7] != a[7]);
        drive(w, 1'b1, a, b, c);
        tick();
        o = outs(w);
        check({tag, ".busy_start"}, {31'd0, o[9]}, 32'd1);
        check({tag, ".hold_start"}, {23'd0, o[8:0]}, {23'd0, prev_carry[w], prev_sum[w]});
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            drive(w, keep_start, 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
            cyc++;
            o = outs(w);
            if (o[10]) begin
                seen = 1'b1;
            end else begin
                check({tag, ".hold"}, {22'd0, o[9:0]}, {22'd0, 1'b1, prev_carry[w], prev_sum[w]});
            end
        end
        check({tag, ".latency"}, cyc, lat(w));
        check({tag, ".sum"}, {24'd0, o[7:0]}, {24'd0, full[7:0]});
        check({tag, ".carry"}, {31'd0, o[8]}, {31'd0, full[8]});
        check({tag, ".busy_done"}, {31'd0, o[9]}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, {31'd0, o[11]}, {31'd0, exp_ovf});
`endif
        prev_sum[w]   = full[7:0];
        prev_carry[w] = full[8];
        prev_ovf[w]   = exp_ovf;
    endtask

    // One idle cycle with start low: done must have dropped, result held.
    task automatic idle(input int w, input string tag);
        logic [11:0] o;
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        tick();
        o = outs(w);
        check({tag, ".idle"}, {22'd0, o[10:0]}, {22'd0, 2'b00, prev_carry[w], prev_sum[w]});
    endtask

    initial begin
        logic [11:0] o;
        rst = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        for (int w = 0; w < 3; w++) begin
            o = outs(w);
            check($sformatf("reset.w%0d", w), {20'd0, o}, 32'd0);
            prev_sum[w]   = 8'h00;
            prev_carry[w] = 1'b0;
            prev_ovf[w]   = 1'b0;
        end
        rst = 1'b0;
        idle(0, "pre");

        // Directed cases
        do_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0, "t1");  idle(0, "t1");
        do_op(0, 8'hFF, 8'h01, 1'b1, 1'b0, "t2");  idle(0, "t2");
        do_op(1, 8'hF0, 8'h10, 1'b0, 1'b0, "t3");  idle(1, "t3");
        do_op(2, 8'hC3, 8'h5E, 1'b1, 1'b0, "tn1"); idle(2, "tn1");

        // Start held through RUN with changing operands, then back-to-back op.
        do_op(0, 8'h12, 8'h34, 1'b0, 1'b1, "t4a");
        do_op(0, 8'hA7, 8'h9C, 1'b1, 1'b0, "t4b");
        idle(0, "t4");

        // Reset before RUN edge 3: abandoned, everything cleared, no done afterwards.
        drive(0, 1'b1, 8'h77, 8'h66, 1'b1);
        tick();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            o = outs(w);
            check($sformatf("t5.rst.w%0d", w), {20'd0, o}, 32'd0);
            prev_sum[w]   = 8'h00;
            prev_carry[w] = 1'b0;
            prev_ovf[w]   = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            o = outs(0);
            check("t5.no_done", {20'd0, o}, 32'd0);
        end
        do_op(0, 8'h81, 8'h7F, 1'b0, 1'b0, "t5post"); idle(0, "t5post");

        // Overflow corner operands on every instance.
        for (int w = 0; w < 3; w++) begin
            do_op(w, 8'h7F, 8'h01, 1'b0, 1'b0, "t6a"); idle(w, "t6a");
            do_op(w, 8'h80, 8'h80, 1'b0, 1'b0, "t6b"); idle(w, "t6b");
        end

        // Randomized operations, with random start holding and chaining.
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 15; i++) begin
                do_op(w, 8'($urandom), 8'($urandom), 1'($urandom),
                      1'($urandom_range(0, 1)), $sformatf("rnd.w%0d.%0d", w, i));
                if ($urandom_range(0, 1) == 1) idle(w, "rnd");
            end
            idle(w, "rnd_end");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
